// File: rtl/frame_sequencer.sv
// frame_sequencer: frame-level initiator for the go/done animation protocol.
//
// A free-running tick counter marks frame boundaries. On each tick the block
// pulses plyr_go, waits for plyr_done (or a watchdog timeout), then does the
// same for the egg animator. While a client is active its pixel stream is
// forwarded to the VGA write port; otherwise the port is held at zero.
//
// Ports:
//   clock, resetn                  system clock, synchronous active-low reset
//   enable                         frames start only while high
//   plyr_go / egg_go               one-cycle start pulses to the animators
//   plyr_done / egg_done           one-cycle completion pulses from animators
//   plyr_* / egg_* pixel fields    client pixel streams (plot, x, y, colour)
//   vga_x/vga_y/vga_colour/vga_plot  muxed pixel stream to the VGA adapter
//   frame_count                    completed frames, wraps 255->0
//   busy                           high while a frame is being drawn
//   timeout_err                    sticky: a client did not answer in time
//   overrun                        sticky: a tick arrived mid-frame
//
// Optional feature: define FRAME_SEQ_OVERRUN_EN to keep one pending frame
// when a tick lands while busy, and to report it on overrun. Without the
// macro, such ticks are dropped and overrun is tied low.

module frame_sequencer #(
   parameter int unsigned FRAME_CYCLES   = 833333,
   parameter int unsigned TIMEOUT_CYCLES = 65535
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       enable,
   output logic       plyr_go,
   input  logic       plyr_done,
   input  logic       plyr_plot,
   input  logic [7:0] plyr_x,
   input  logic [6:0] plyr_y,
   input  logic [2:0] plyr_colour,
   output logic       egg_go,
   input  logic       egg_done,
   input  logic       egg_plot,
   input  logic [7:0] egg_x,
   input  logic [6:0] egg_y,
   input  logic [2:0] egg_colour,
   output logic [7:0] vga_x,
   output logic [6:0] vga_y,
   output logic [2:0] vga_colour,
   output logic       vga_plot,
   output logic [7:0] frame_count,
   output logic       busy,
   output logic       timeout_err,
   output logic       overrun
);

   localparam int unsigned TickW = (FRAME_CYCLES > 2) ? $clog2(FRAME_CYCLES) : 1;
   localparam logic [TickW-1:0] TickLast = TickW'(FRAME_CYCLES - 1);
   localparam logic [15:0]      WdLast   = 16'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      StIdle,
      StWaitTick,
      StGoPlyr,
      StBusyPlyr,
      StGoEgg,
      StBusyEgg
   } state_e;

   state_e            state_q, state_d;
   logic [TickW-1:0]  tick_cnt_q;
   logic              tick;
   logic [15:0]       wd_q, wd_d;
   logic [7:0]        frame_cnt_q, frame_cnt_d;
   logic              busy_q, busy_d;
   logic              timeout_err_q, timeout_err_d;
   // Set when either client of the current frame timed out; such a frame is
   // not counted as completed.
   logic              frame_bad_q, frame_bad_d;
   logic              pending_w;

   //---------------------------------------------------------------------------
   // Frame tick counter
   //---------------------------------------------------------------------------
   assign tick = enable && (tick_cnt_q == TickLast);

   always_ff @(posedge clock) begin
      if (!resetn) begin
         tick_cnt_q <= '0;
      end else if (!enable || tick) begin
         tick_cnt_q <= '0;
      end else begin
         tick_cnt_q <= tick_cnt_q + TickW'(1);
      end
   end

   //---------------------------------------------------------------------------
   // Optional pending-frame / overrun tracking
   //---------------------------------------------------------------------------
`ifdef FRAME_SEQ_OVERRUN_EN
   logic pending_q, pending_d;
   logic overrun_q, overrun_d;

   always_comb begin
      pending_d = pending_q;
      overrun_d = overrun_q;
      // busy_q mirrors the GO/BUSY states, so a tick while busy can never
      // coincide with the WAIT_TICK exit that consumes the pending frame.
      if (state_q == StWaitTick && state_d != StWaitTick) begin
         pending_d = 1'b0;
      end
      if (tick && busy_q) begin
         pending_d = 1'b1;
         overrun_d = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         pending_q <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         pending_q <= pending_d;
         overrun_q <= overrun_d;
      end
   end

   assign pending_w = pending_q;
   assign overrun   = overrun_q;
`else
   assign pending_w = 1'b0;
   assign overrun   = 1'b0;
`endif

   //---------------------------------------------------------------------------
   // Sequencer FSM
   //---------------------------------------------------------------------------
   always_comb begin
      state_d       = state_q;
      wd_d          = wd_q;
      frame_cnt_d   = frame_cnt_q;
      timeout_err_d = timeout_err_q;
      frame_bad_d   = frame_bad_q;

      unique case (state_q)
         StIdle: begin
            if (enable) state_d = StWaitTick;
         end
         StWaitTick: begin
            if (!enable) begin
               state_d = StIdle;
            end else if (tick || pending_w) begin
               state_d = StGoPlyr;
            end
         end
         StGoPlyr: begin
            wd_d        = '0;
            frame_bad_d = 1'b0;
            state_d     = StBusyPlyr;
         end
         StBusyPlyr: begin
            wd_d = wd_q + 16'd1;
            if (plyr_done) begin
               state_d = StGoEgg;
            end else if (wd_q == WdLast) begin
               timeout_err_d = 1'b1;
               frame_bad_d   = 1'b1;
               state_d       = StGoEgg;
            end
         end
         StGoEgg: begin
            wd_d    = '0;
            state_d = StBusyEgg;
         end
         StBusyEgg: begin
            wd_d = wd_q + 16'd1;
            if (egg_done) begin
               if (!frame_bad_q) frame_cnt_d = frame_cnt_q + 8'd1;
               state_d = StWaitTick;
            end else if (wd_q == WdLast) begin
               timeout_err_d = 1'b1;
               frame_bad_d   = 1'b1;
               state_d       = StWaitTick;
            end
         end
         default: state_d = StIdle;
      endcase

      busy_d = (state_d == StGoPlyr) || (state_d == StBusyPlyr) ||
               (state_d == StGoEgg)  || (state_d == StBusyEgg);
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q       <= StIdle;
         wd_q          <= '0;
         frame_cnt_q   <= '0;
         busy_q        <= 1'b0;
         timeout_err_q <= 1'b0;
         frame_bad_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         wd_q          <= wd_d;
         frame_cnt_q   <= frame_cnt_d;
         busy_q        <= busy_d;
         timeout_err_q <= timeout_err_d;
         frame_bad_q   <= frame_bad_d;
      end
   end

   //---------------------------------------------------------------------------
   // Outputs
   //---------------------------------------------------------------------------
   assign plyr_go     = (state_q == StGoPlyr);
   assign egg_go      = (state_q == StGoEgg);
   assign frame_count = frame_cnt_q;
   assign busy        = busy_q;
   assign timeout_err = timeout_err_q;

   // Zero-latency pixel mux; only the client in its BUSY state is forwarded.
   always_comb begin
      vga_x      = '0;
      vga_y      = '0;
      vga_colour = '0;
      vga_plot   = 1'b0;
      if (state_q == StBusyPlyr) begin
         vga_x      = plyr_x;
         vga_y      = plyr_y;
         vga_colour = plyr_colour;
         vga_plot   = plyr_plot;
      end else if (state_q == StBusyEgg) begin
         vga_x      = egg_x;
         vga_y      = egg_y;
         vga_colour = egg_colour;
         vga_plot   = egg_plot;
      end
   end

endmodule

// File: tb/tb_frame_sequencer.sv
// Self-checking bench for frame_sequencer (default build, overrun feature off).
// A directed script walks the normal, mux, timeout, reset and enable-drop
// scenarios; random stimulus follows. Every cycle all outputs are compared
// against a behavioural model of the frame protocol.

module tb_frame_sequencer;

   localparam int unsigned F = 16;
   localparam int unsigned T = 8;

   logic       clock = 1'b0;
   logic       resetn, enable;
   logic       plyr_go, plyr_done, plyr_plot;
   logic [7:0] plyr_x;
   logic [6:0] plyr_y;
   logic [2:0] plyr_colour;
   logic       egg_go, egg_done, egg_plot;
   logic [7:0] egg_x;
   logic [6:0] egg_y;
   logic [2:0] egg_colour;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] vga_colour;
   logic       vga_plot;
   logic [7:0] frame_count;
   logic       busy, timeout_err, overrun;

   always #5 clock = ~clock;

   frame_sequencer #(
      .FRAME_CYCLES   (F),
      .TIMEOUT_CYCLES (T)
   ) dut (
      .clock       (clock),
      .resetn      (resetn),
      .enable      (enable),
      .plyr_go     (plyr_go),
      .plyr_done   (plyr_done),
      .plyr_plot   (plyr_plot),
      .plyr_x      (plyr_x),
      .plyr_y      (plyr_y),
      .plyr_colour (plyr_colour),
      .egg_go      (egg_go),
      .egg_done    (egg_done),
      .egg_plot    (egg_plot),
      .egg_x       (egg_x),
      .egg_y       (egg_y),
      .egg_colour  (egg_colour),
      .vga_x       (vga_x),
      .vga_y       (vga_y),
      .vga_colour  (vga_colour),
      .vga_plot    (vga_plot),
      .frame_count (frame_count),
      .busy        (busy),
      .timeout_err (timeout_err),
      .overrun     (overrun)
   );

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Behavioural model: frame phase, frame-relative tick position, client wait
   // time, and the externally visible counters/flags.
   localparam int PhIdle = 0, PhWait = 1, PhGoP = 2, PhBusyP = 3, PhGoE = 4, PhBusyE = 5;
   int m_phase, m_cnt, m_wd, m_frames;
   bit m_terr, m_bad;

   task automatic model_reset();
      m_phase = PhIdle; m_cnt = 0; m_wd = 0; m_frames = 0; m_terr = 0; m_bad = 0;
   endtask

   task automatic model_step();
      bit tick;
      if (!resetn) begin
         model_reset();
         return;
      end
      tick  = enable && (m_cnt == int'(F) - 1);
      m_cnt = (!enable || tick) ? 0 : m_cnt + 1;
      case (m_phase)
         PhIdle: if (enable) m_phase = PhWait;
         PhWait: begin
            if (!enable) m_phase = PhIdle;
            else if (tick) m_phase = PhGoP;
         end
         PhGoP: begin m_wd = 0; m_bad = 0; m_phase = PhBusyP; end
         PhBusyP: begin
            if (plyr_done) m_phase = PhGoE;
            else if (m_wd == int'(T) - 1) begin m_terr = 1; m_bad = 1; m_phase = PhGoE; end
            else m_wd++;
         end
         PhGoE: begin m_wd = 0; m_phase = PhBusyE; end
         PhBusyE: begin
            if (egg_done) begin
               if (!m_bad) m_frames = (m_frames + 1) % 256;
               m_phase = PhWait;
            end else if (m_wd == int'(T) - 1) begin
               m_terr = 1; m_phase = PhWait;
            end else m_wd++;
         end
         default: m_phase = PhIdle;
      endcase
   endtask

   task automatic compare_all();
      logic [7:0] ex; logic [6:0] ey; logic [2:0] ec; logic ep;
      ex = '0; ey = '0; ec = '0; ep = 1'b0;
      if (m_phase == PhBusyP) begin
         ex = plyr_x; ey = plyr_y; ec = plyr_colour; ep = plyr_plot;
      end else if (m_phase == PhBusyE) begin
         ex = egg_x; ey = egg_y; ec = egg_colour; ep = egg_plot;
      end
      check_eq("go", 32'({plyr_go, egg_go}), 32'({m_phase == PhGoP, m_phase == PhGoE}));
      check_eq("vga", 32'({vga_x, vga_y, vga_colour, vga_plot}), 32'({ex, ey, ec, ep}));
      check_eq("frame_count", 32'(frame_count), 32'(m_frames));
      check_eq("flags", 32'({busy, timeout_err, overrun}),
               32'({m_phase >= PhGoP, m_terr, 1'b0}));
   endtask

   // Inputs are driven at the falling edge; sample() checks 1 time unit later,
   // advance() updates the model and moves to the next falling edge.
   task automatic sample();
      #1 compare_all();
   endtask

   task automatic advance();
      model_step();
      @(negedge clock);
   endtask

   task automatic quiet();
      plyr_done = 0; plyr_plot = 0; plyr_x = 0; plyr_y = 0; plyr_colour = 0;
      egg_done = 0; egg_plot = 0; egg_x = 0; egg_y = 0; egg_colour = 0;
   endtask

   initial begin
      resetn = 0; enable = 0;
      quiet();
      @(negedge clock);
      @(negedge clock);
      model_reset();
      sample();
      advance();

      // Directed scenarios; cycle 0 is the first cycle with enable high.
      for (int c = 0; c < 96; c++) begin
         quiet();
         resetn = (c != 53);
         enable = (c < 72);
         case (c)
            10: plyr_plot = 1;
            18: begin
               plyr_plot = 1; plyr_x = 8'd40; plyr_y = 7'd100; plyr_colour = 3'd3;
               egg_plot = 1; egg_x = 8'd7; egg_y = 7'd9; egg_colour = 3'd5;
            end
            21: plyr_done = 1;
            24: egg_done = 1;
            43: egg_done = 1;
            50: plyr_done = 1;
            73: plyr_done = 1;
            76: egg_done = 1;
            80: begin plyr_done = 1; egg_done = 1; end
            default: ;
         endcase
         sample();
         case (c)
            10: check_eq("idle_plot", 32'(vga_plot), 32'(0));
            15: check_eq("no_go_c15", 32'(plyr_go), 32'(0));
            16: check_eq("plyr_go_c16", 32'(plyr_go), 32'(1));
            18: check_eq("mux_plyr", 32'({vga_x, vga_y, vga_colour, vga_plot}),
                         32'({8'd40, 7'd100, 3'd3, 1'b1}));
            22: check_eq("egg_go_c22", 32'(egg_go), 32'(1));
            25: check_eq("frame1", 32'({frame_count, busy}), 32'({8'd1, 1'b0}));
            41: check_eq("egg_go_timeout", 32'(egg_go), 32'(1));
            44: check_eq("timeout_nocount", 32'({frame_count, timeout_err}), 32'({8'd1, 1'b1}));
            54: check_eq("after_reset", 32'({frame_count, timeout_err, busy, plyr_go, egg_go}),
                         32'(0));
            69: check_eq("no_go_c69", 32'(plyr_go), 32'(0));
            70: check_eq("plyr_go_c70", 32'(plyr_go), 32'(1));
            74: check_eq("egg_go_en_low", 32'(egg_go), 32'(1));
            77: check_eq("frame_en_low", 32'(frame_count), 32'(1));
            95: check_eq("stay_idle", 32'({busy, plyr_go}), 32'(0));
            default: ;
         endcase
         advance();
      end

      // Randomized stimulus.
      for (int c = 0; c < 4000; c++) begin
         resetn      = ($urandom_range(0, 199) != 0);
         enable      = ($urandom_range(0, 29) != 0);
         plyr_done   = ($urandom_range(0, 7) == 0);
         egg_done    = ($urandom_range(0, 7) == 0);
         plyr_plot   = 1'($urandom);
         egg_plot    = 1'($urandom);
         plyr_x      = 8'($urandom);
         plyr_y      = 7'($urandom);
         plyr_colour = 3'($urandom);
         egg_x       = 8'($urandom);
         egg_y       = 7'($urandom);
         egg_colour  = 3'($urandom);
         sample();
         advance();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
- Frame-level initiator for the go/done animation protocol. It generates the frame tick and issues `go` to the player animator and then the egg animator, one at a time.
- It waits for each client's `done` and multiplexes the active client's pixel stream onto the single VGA adapter write port.
- It sits between the game top level and the VGA adapter, above the per-object animate blocks.

Parameters:
- FRAME_CYCLES, 833333: clock cycles per frame (50 MHz / 60 Hz); minimum value 16.
- TIMEOUT_CYCLES, 65535: maximum cycles to wait for a client `done` before aborting that client.

Ports:
- clock  in  1  system clock
- resetn  in  1  synchronous active-low reset
- enable  in  1  game running; frames start only while high
- plyr_go  out  1  one-cycle start pulse to player animator
- plyr_done  in  1  player animator finished (one-cycle pulse)
- plyr_plot  in  1  player pixel valid
- plyr_x  in  8  player pixel x
- plyr_y  in  7  player pixel y
- plyr_colour  in  3  player pixel colour
- egg_go  out  1  one-cycle start pulse to egg animator
- egg_done  in  1  egg animator finished (one-cycle pulse)
- egg_plot, egg_x[8], egg_y[7], egg_colour[3]  in  egg pixel stream, same meaning as the player fields
- vga_x  out  8  to VGA adapter
- vga_y  out  7  to VGA adapter
- vga_colour  out  3  to VGA adapter
- vga_plot  out  1  VGA write enable
- frame_count  out  8  completed frames, wraps 255->0
- busy  out  1  high in any state other than IDLE/WAIT_TICK
- timeout_err  out  1  sticky: a client timed out
- overrun  out  1  sticky: tick arrived while busy (optional feature)

Behaviour:
- Reset: on clock edge with resetn=0, state=IDLE and all counters=0.
  - All outputs go to 0; sticky flags cleared.
  - Reset mid-draw aborts immediately. No `go` is re-issued until a new tick.
- Tick counter: free-runs 0..FRAME_CYCLES-1 while enable=1; held at 0 while enable=0.
  - `tick` is asserted for one cycle when the count equals FRAME_CYCLES-1, then the count wraps to 0.
- States and transitions:
  - IDLE -> WAIT_TICK when enable=1.
  - WAIT_TICK -> GO_PLYR on tick. Returns to IDLE if enable=0.
  - GO_PLYR: plyr_go=1 for exactly this one cycle; watchdog cleared. Next state BUSY_PLYR.
  - BUSY_PLYR: waits for plyr_done. Goes to GO_EGG on done or on watchdog == TIMEOUT_CYCLES-1 (timeout sets timeout_err).
  - GO_EGG / BUSY_EGG: same as the player pair. On exit, frame_count increments; next state WAIT_TICK.
  - Timeout exit does not count as a completed frame.
- Dropping enable mid-frame does not abort the frame. The sequence completes, then the block goes to IDLE.
- A `done` seen in any state other than the matching BUSY state is ignored.
- Pixel mux (combinational, zero latency):
  - BUSY_PLYR: vga_* = plyr_*, vga_plot = plyr_plot.
  - BUSY_EGG: vga_* = egg_*, vga_plot = egg_plot.
  - Otherwise: vga_x, vga_y, vga_colour, vga_plot = 0.
- Only one client is driven per cycle. A plot from the inactive client is never forwarded.
- Watchdog: 16-bit counter, increments each cycle in BUSY states, cleared in GO states.
- busy is registered from the state: high in GO_* and BUSY_*.

Optional Feature:
- FRAME_SEQ_OVERRUN_EN defined:
  - A tick arriving while busy=1 sets sticky overrun and a single pending flag.
  - On returning to WAIT_TICK with the pending flag set, the block goes straight to GO_PLYR next cycle and clears the flag.
  - Further ticks while the flag is already pending are lost; overrun stays set.
- Undefined: ticks while busy are ignored, no pending frame is kept, and overrun is tied to 0.

Test Plan:
- Normal frame (FRAME_CYCLES=16, enable=1 from reset): plyr_go pulses at cycle 16 (count from enable). Return plyr_done 5 cycles later -> egg_go pulses the next cycle. Return egg_done -> frame_count=1, state WAIT_TICK.
- Mux isolation: in BUSY_PLYR drive plyr_plot=1, x=40, y=100, colour=3 together with egg_plot=1, x=7 -> vga_x=40, vga_y=100, vga_colour=3, vga_plot=1. Idle cycles show vga_plot=0.
- Timeout (TIMEOUT_CYCLES=8): never assert plyr_done -> egg_go pulses 8 cycles after plyr_go+1. timeout_err=1, and frame_count unchanged after egg_done.
- Overrun (macro defined, FRAME_CYCLES=16): hold plyr_done off for 20 cycles -> overrun=1. After egg_done, plyr_go fires 2 cycles later without waiting for a tick. With the macro undefined, overrun=0 and the next go waits for the tick.
- Reset mid-BUSY_EGG: resetn=0 for one cycle -> all outputs 0, frame_count=0, no egg_go or plyr_go until the next full FRAME_CYCLES period.
- enable dropped during BUSY_PLYR: the frame finishes (egg_go issued, frame_count increments), then IDLE. No further go pulses.
